// File: rtl/mem_req_scheduler.sv
// Round-robin arbiter sharing one memory port among NUM_INPUTS LSU requesters, with per-requester
// read-credit limiting and tag-indexed response routing.
module mem_req_scheduler #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned SEL_BITS      = $clog2(NUM_INPUTS),
  localparam int unsigned OUT_TAG_WIDTH = TAG_WIDTH + SEL_BITS,
  localparam int unsigned CNT_W         = $clog2(MAX_PENDING + 1),
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_req_valid,
  input  logic [NUM_INPUTS-1:0]            in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_INPUTS*BE_WIDTH-1:0]   in_req_byteen,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_INPUTS-1:0]            in_req_ready,
  output logic [NUM_INPUTS-1:0]            in_rsp_valid,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] in_rsp_data,
  output logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]            in_rsp_ready,
  output logic                             out_req_valid,
  output logic                             out_req_rw,
  output logic [ADDR_WIDTH-1:0]            out_req_addr,
  output logic [BE_WIDTH-1:0]              out_req_byteen,
  output logic [DATA_WIDTH-1:0]            out_req_data,
  output logic [OUT_TAG_WIDTH-1:0]         out_req_tag,
  input  logic                             out_req_ready,
  input  logic                             out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            out_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]         out_rsp_tag,
  output logic                             out_rsp_ready
);

  logic                     r_out_valid;
  logic                     r_out_rw;
  logic [ADDR_WIDTH-1:0]    r_out_addr;
  logic [BE_WIDTH-1:0]      r_out_byteen;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic [OUT_TAG_WIDTH-1:0] r_out_tag;
  logic [SEL_BITS-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]         r_cnt [NUM_INPUTS];

  logic                     w_free;
  logic [NUM_INPUTS-1:0]    w_elig;
  logic [NUM_INPUTS-1:0]    w_grant;
  logic                     w_grant_any;
  logic [SEL_BITS-1:0]      w_grant_idx;
  logic [SEL_BITS-1:0]      w_cand;
  logic                     w_rw;
  logic [ADDR_WIDTH-1:0]    w_addr;
  logic [BE_WIDTH-1:0]      w_byteen;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [TAG_WIDTH-1:0]     w_tag;
  logic [NUM_INPUTS-1:0]    w_inc;
  logic [NUM_INPUTS-1:0]    w_dec;
  logic [SEL_BITS-1:0]      w_rsp_sel;
  logic                     w_rsp_sel_ok;
  logic                     w_rsp_fire;

  assign w_free = !r_out_valid || out_req_ready;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_elig[i] = in_req_valid[i] && (in_req_rw[i] || (r_cnt[i] < CNT_W'(MAX_PENDING)));
    end
  end

  // Cyclic search starting at the round-robin pointer; first eligible candidate wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      w_cand = SEL_BITS'((32'(r_rr_ptr) + k) % NUM_INPUTS);
      if (reset && w_free && !w_grant_any && w_elig[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_grant  = '0;
    w_inc    = '0;
    w_rw     = 1'b0;
    w_addr   = '0;
    w_byteen = '0;
    w_data   = '0;
    w_tag    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_grant[i] = w_grant_any && (w_grant_idx == SEL_BITS'(i));
      w_inc[i]   = w_grant[i] && !in_req_rw[i];
      if (w_grant_idx == SEL_BITS'(i)) begin
        w_rw     = in_req_rw[i];
        w_addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_byteen = in_req_byteen[i*BE_WIDTH +: BE_WIDTH];
        w_data   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_tag    = in_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign in_req_ready = w_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_grant_any) begin
      r_out_valid <= 1'b1;
      r_rr_ptr    <= (w_grant_idx == SEL_BITS'(NUM_INPUTS - 1)) ? '0 :
                     w_grant_idx + SEL_BITS'(1);
    end else if (w_free) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant_any) begin
      r_out_rw     <= w_rw;
      r_out_addr   <= w_addr;
      r_out_byteen <= w_byteen;
      r_out_data   <= w_data;
      r_out_tag    <= {w_tag, w_grant_idx};
    end
  end

  assign out_req_valid  = r_out_valid;
  assign out_req_rw     = r_out_rw;
  assign out_req_addr   = r_out_addr;
  assign out_req_byteen = r_out_byteen;
  assign out_req_data   = r_out_data;
  assign out_req_tag    = r_out_tag;

  assign w_rsp_sel    = out_rsp_tag[SEL_BITS-1:0];
  assign w_rsp_sel_ok = (32'(w_rsp_sel) < NUM_INPUTS);
  assign w_rsp_fire   = out_rsp_valid && out_rsp_ready;

  // An out-of-range index matches no lane, so the response is dropped with ready held high.
  always_comb begin
    in_rsp_valid  = '0;
    out_rsp_ready = 1'b1;
    in_rsp_tag    = '0;
    w_dec         = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_rsp_tag[i*TAG_WIDTH +: TAG_WIDTH] = out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS];
      if (w_rsp_sel == SEL_BITS'(i)) begin
        in_rsp_valid[i] = out_rsp_valid;
        out_rsp_ready   = in_rsp_ready[i];
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_dec[i] = w_rsp_fire && w_rsp_sel_ok && (w_rsp_sel == SEL_BITS'(i)) && (r_cnt[i] != '0);
    end
  end

  assign in_rsp_data = {NUM_INPUTS{out_rsp_data}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!reset) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end else if (w_dec[i] && !w_inc[i]) begin
        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && out_rsp_valid) begin
      assert (w_rsp_sel_ok) else $error("mem_req_scheduler: response index out of range");
      if (w_rsp_sel_ok && out_rsp_ready) begin
        assert (r_cnt[w_rsp_sel] != '0) else $error("mem_req_scheduler: response with no credit");
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Scoreboard bench for mem_req_scheduler: fairness, credits, write bypass, backpressure,
// response routing and mid-traffic reset.
module tb_mem_req_scheduler;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [TW+1:0] tag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          rw;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*BW-1:0] in_req_byteen;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [N*DW-1:0] in_rsp_data;
  logic [N*TW-1:0] in_rsp_tag;
  logic            out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]   out_req_addr;
  logic [BW-1:0]   out_req_byteen;
  logic [DW-1:0]   out_req_data;
  logic [TW+1:0]   out_req_tag;
  logic            out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]   out_rsp_data;
  logic [TW+1:0]   out_rsp_tag;

  mem_req_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .in_req_valid  (in_req_valid),
    .in_req_rw     (in_req_rw),
    .in_req_addr   (in_req_addr),
    .in_req_byteen (in_req_byteen),
    .in_req_data   (in_req_data),
    .in_req_tag    (in_req_tag),
    .in_req_ready  (in_req_ready),
    .in_rsp_valid  (in_rsp_valid),
    .in_rsp_data   (in_rsp_data),
    .in_rsp_tag    (in_rsp_tag),
    .in_rsp_ready  (in_rsp_ready),
    .out_req_valid (out_req_valid),
    .out_req_rw    (out_req_rw),
    .out_req_addr  (out_req_addr),
    .out_req_byteen(out_req_byteen),
    .out_req_data  (out_req_data),
    .out_req_tag   (out_req_tag),
    .out_req_ready (out_req_ready),
    .out_rsp_valid (out_rsp_valid),
    .out_rsp_data  (out_rsp_data),
    .out_rsp_tag   (out_rsp_tag),
    .out_rsp_ready (out_rsp_ready)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  item_t sb[$];
  logic  held = 1'b0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i, input logic [7:0] t);
    return {16'hA000, 6'(i), 2'b00, t};
  endfunction

  function automatic logic [BW-1:0] be_of(input int i);
    return 4'hF >> i;
  endfunction

  task automatic set_req(input int i, input logic v, input logic rw, input logic [7:0] t);
    in_req_valid[i]           = v;
    in_req_rw[i]              = rw;
    in_req_tag[i*TW +: TW]    = t;
    in_req_addr[i*AW +: AW]   = addr_of(i, t);
    in_req_data[i*DW +: DW]   = addr_of(i, t) ^ 32'h5A5A_5A5A;
    in_req_byteen[i*BW +: BW] = be_of(i);
  endtask

  task automatic push_exp(input int i, input logic rw, input logic [7:0] t);
    item_t it;
    it.tag  = {t, 2'(i)};
    it.addr = addr_of(i, t);
    it.data = addr_of(i, t) ^ 32'h5A5A_5A5A;
    it.be   = be_of(i);
    it.rw   = rw;
    sb.push_back(it);
  endtask

  task automatic check_cnt(input int i, input int exp);
    check_eq($sformatf("cnt%0d", i), 64'(dut.r_cnt[i]), 64'(exp));
  endtask

  // A new output item is any valid cycle not preceded by a stalled cycle.
  always @(negedge clk) begin
    item_t e;
    #2;
    if (out_req_valid && !held) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_issue", 64'(out_req_tag), 64'h3FF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("out_tag", 64'(out_req_tag), 64'(e.tag));
        check_eq("out_addr", 64'(out_req_addr), 64'(e.addr));
        check_eq("out_data", 64'(out_req_data), 64'(e.data));
        check_eq("out_be", 64'(out_req_byteen), 64'(e.be));
        check_eq("out_rw", 64'(out_req_rw), 64'(e.rw));
      end
    end
    held = reset && out_req_valid && !out_req_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int idx;
    reset         = 1'b0;
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_byteen = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    in_rsp_ready  = '1;
    out_req_ready = 1'b0;
    out_rsp_valid = 1'b0;
    out_rsp_data  = '0;
    out_rsp_tag   = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 8'(8'h10 + i));

    // Reset state, with all requesters asserting valid.
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_req_valid), 0);
    check_eq("rst_ready", 64'(in_req_ready), 0);
    check_eq("rst_ptr", 64'(dut.r_rr_ptr), 0);
    for (int i = 0; i < N; i++) check_cnt(i, 0);

    // Fairness: 12 back-to-back grants in order 0,1,2,3,... with immediate responses.
    @(negedge clk);
    reset         = 1'b1;
    out_req_ready = 1'b1;
    for (int k = 0; k < 12; k++) push_exp(k % N, 1'b0, 8'(8'h10 + (k % N)));
    #1;
    check_eq("fair_first_ready", 64'(in_req_ready), 64'h1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 12) in_req_valid = '0;
      if (k <= 12) begin
        idx           = (k - 1) % N;
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {8'(8'h10 + idx), 2'(idx)};
        out_rsp_data  = 32'hD000_0000 + 32'(k);
        #1;
        check_eq("fair_valid", 64'(out_req_valid), 1);
        check_eq("rsp_valid_route", 64'(in_rsp_valid), 64'(4'b0001 << idx));
        check_eq("rsp_ready", 64'(out_rsp_ready), 1);
        check_eq("rsp_tag", 64'(in_rsp_tag[idx*TW +: TW]), 64'(8'h10 + idx));
        check_eq("rsp_data", 64'(in_rsp_data[idx*DW +: DW]), 64'(32'hD000_0000 + 32'(k)));
      end else begin
        out_rsp_valid = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check_cnt(i, 0);
        check_eq("fair_ptr", 64'(dut.r_rr_ptr), 0);
      end
    end

    // Credit limit on requester 2: four reads accepted, then blocked.
    g = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_req(2, 1'b1, 1'b0, 8'(8'h20 + g));
      #1;
      check_eq("credit_ready", 64'(in_req_ready[2]), 64'(k < 4));
      if (k < 4) begin
        push_exp(2, 1'b0, 8'(8'h20 + g));
        g++;
      end
    end
    @(negedge clk);
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h20, 2'd2};
    #1;
    check_cnt(2, 4);
    check_eq("credit_blocked", 64'(in_req_ready[2]), 0);
    check_eq("credit_rsp_ready", 64'(out_rsp_ready), 1);
    @(negedge clk);
    out_rsp_valid = 1'b0;
    #1;
    check_eq("credit_freed_ready", 64'(in_req_ready[2]), 1);
    push_exp(2, 1'b0, 8'h24);
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 8'h25);
    #1;
    check_cnt(2, 4);

    // Requester 1: fill credits with reads, then writes still pass.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      set_req(1, 1'b1, 1'(k >= 4), 8'(8'h50 + k));
      #1;
      check_eq(k >= 4 ? "write_ready" : "read_ready", 64'(in_req_ready[1]), 1);
      push_exp(1, 1'(k >= 4), 8'(8'h50 + k));
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 8'h00);
    #1;
    check_cnt(1, 4);

    // Backpressure: pointer is at 2, so requester 3 wins first, then the stall holds.
    @(negedge clk);
    out_req_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h60);
    set_req(3, 1'b1, 1'b0, 8'h70);
    #1;
    check_eq("bp_grant", 64'(in_req_ready), 64'h8);
    push_exp(3, 1'b0, 8'h70);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_req(3, 1'b0, 1'b0, 8'h71);
      #1;
      check_eq("bp_ready", 64'(in_req_ready), 0);
      check_eq("bp_hold_tag", 64'(out_req_tag), 64'({8'h70, 2'd3}));
      check_eq("bp_hold_addr", 64'(out_req_addr), 64'(addr_of(3, 8'h70)));
      check_eq("bp_ptr", 64'(dut.r_rr_ptr), 0);
    end
    @(negedge clk);
    out_req_ready = 1'b1;
    set_req(3, 1'b1, 1'b0, 8'h71);
    #1;
    check_eq("bp_resume0", 64'(in_req_ready), 64'h1);
    push_exp(0, 1'b0, 8'h60);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 8'h61);
    #1;
    check_eq("bp_resume3", 64'(in_req_ready), 64'h8);
    push_exp(3, 1'b0, 8'h71);
    @(negedge clk);
    set_req(3, 1'b0, 1'b0, 8'h72);

    // Response routing with the target lane not ready.
    @(negedge clk);
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'hA5, 2'd3};
    out_rsp_data  = 32'hCAFE_F00D;
    in_rsp_ready  = 4'b0111;
    #1;
    check_eq("route_valid", 64'(in_rsp_valid), 64'h8);
    check_eq("route_tag", 64'(in_rsp_tag[3*TW +: TW]), 64'hA5);
    check_eq("route_data", 64'(in_rsp_data[3*DW +: DW]), 64'hCAFE_F00D);
    check_eq("route_ready", 64'(out_rsp_ready), 0);
    @(negedge clk);
    #1;
    check_cnt(3, 2);
    in_rsp_ready = '1;
    #1;
    check_eq("route_ready_hs", 64'(out_rsp_ready), 1);
    @(negedge clk);
    out_rsp_valid = 1'b0;
    #1;
    check_cnt(3, 1);

    // Reset while a request is in the output stage and credits are outstanding.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h62);
    #1;
    check_eq("mid_grant", 64'(in_req_ready), 64'h1);
    push_exp(0, 1'b0, 8'h62);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_valid_before", 64'(out_req_valid), 1);
    check_eq("mid_ready_in_reset", 64'(in_req_ready), 0);
    @(negedge clk);
    #1;
    check_eq("mid_out_valid", 64'(out_req_valid), 0);
    check_eq("mid_ptr", 64'(dut.r_rr_ptr), 0);
    check_eq("mid_ready_held", 64'(in_req_ready), 0);
    for (int i = 0; i < N; i++) check_cnt(i, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("post_rst_grant", 64'(in_req_ready), 64'h1);
    push_exp(0, 1'b0, 8'h62);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #3;
    check_eq("sb_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Shares one memory request/response port between NUM_INPUTS LSU requesters with round-robin arbitration and per-requester read-credit limiting. Sits between the per-block LSU memory interfaces and a single dcache (or local-memory) bank port. Appends the requester index to the outgoing tag and routes each response back to its originator by that index. The request path is registered (one cycle); the response path is combinational.

## Interface
- NUM_INPUTS, 4: number of requesters; ≥2.
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: data width in bits; byte-enable width is DATA_WIDTH/8.
- TAG_WIDTH, 8: input tag width.
- MAX_PENDING, 4: maximum outstanding reads per requester; ≥1.
- Derived: SEL_BITS = clog2(NUM_INPUTS); OUT_TAG_WIDTH = TAG_WIDTH + SEL_BITS; CNT_W = clog2(MAX_PENDING+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge).
- in_req_valid  in  NUM_INPUTS  per-requester request valid.
- in_req_rw  in  NUM_INPUTS  1=write, 0=read.
- in_req_addr  in  NUM_INPUTS×ADDR_WIDTH  request address.
- in_req_byteen  in  NUM_INPUTS×DATA_WIDTH/8  byte enables.
- in_req_data  in  NUM_INPUTS×DATA_WIDTH  write data.
- in_req_tag  in  NUM_INPUTS×TAG_WIDTH  request tag.
- in_req_ready  out  NUM_INPUTS  per-requester accept.
- in_rsp_valid  out  NUM_INPUTS  response valid.
- in_rsp_data  out  NUM_INPUTS×DATA_WIDTH  response data (broadcast to all requesters).
- in_rsp_tag  out  NUM_INPUTS×TAG_WIDTH  original tag.
- in_rsp_ready  in  NUM_INPUTS  per-requester response accept.
- out_req_valid / out_req_rw / out_req_addr / out_req_byteen / out_req_data  out  1/1/ADDR_WIDTH/DATA_WIDTH/8/DATA_WIDTH  registered request.
- out_req_tag  out  OUT_TAG_WIDTH  {input tag, requester index}; index in the LSBs.
- out_req_ready  in  1  downstream accept.
- out_rsp_valid  in  1  response valid (reads only).
- out_rsp_data  in  DATA_WIDTH  response data.
- out_rsp_tag  in  OUT_TAG_WIDTH  returned tag.
- out_rsp_ready  out  1  response accept.

## Operation
- Output stage is free when !out_req_valid || out_req_ready.
- Requester i is eligible when in_req_valid[i] && (in_req_rw[i] || cnt[i] < MAX_PENDING).
- When the stage is free, grant the first eligible requester at or after rr_ptr (cyclic search). At most one grant per cycle.
- in_req_ready[i] = grant[i]. Holding valid without a grant is legal; the requester's payload must stay stable.
- On a grant: load the output register with the payload and tag {in_req_tag[i], i}, set out_req_valid=1, and set rr_ptr=(i+1) mod NUM_INPUTS. With no grant, rr_ptr is unchanged.
- When the stage is free and no requester is eligible, out_req_valid becomes 0.
- Credits: cnt[i] increments on a granted read. It decrements on a response handshake (out_rsp_valid && out_rsp_ready) whose index field equals i. A simultaneous increment and decrement for the same i leaves cnt[i] unchanged. Writes never consume credit.
- Response routing: sel = out_rsp_tag[SEL_BITS-1:0].
  - in_rsp_valid[sel] = out_rsp_valid; all other valids are 0.
  - in_rsp_tag[sel] = out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS].
  - out_rsp_ready = in_rsp_ready[sel].
- A response arriving for a requester with cnt==0 is a protocol error. The response is still routed, cnt saturates at 0, and a simulation assertion fires.
- An index ≥ NUM_INPUTS (NUM_INPUTS not a power of 2) fires an assertion; the response is dropped with out_rsp_ready=1.

## Timing
- Reset values: out_req_valid=0, all cnt=0, rr_ptr=0. While reset==0, in_req_ready=0. The output payload registers are don't-care.
- Request latency: a grant in cycle N presents out_req_valid in cycle N+1.
- Back-to-back: with out_req_ready=1 held, one request is issued per cycle. Full throughput with no bubble.
- Stall: while out_req_valid && !out_req_ready, the output register holds, all in_req_ready=0, and rr_ptr is frozen.
- Response path: zero cycles, purely combinational. cnt updates at the clock edge of the response handshake, so a freed credit makes its requester eligible in the next cycle.
- Reset asserted mid-operation: all in-flight bookkeeping is discarded at that edge. Downstream must also be reset, since the block tracks no response after reset.

## Test plan
- Fairness: all 4 requesters issue reads continuously, out_req_ready=1, responses returned at once → grant order 0,1,2,3,0,1… with one out_req_valid per cycle; out_req_tag LSBs match that order.
- Credit limit: MAX_PENDING=4, requester 2 issues 6 reads with no responses → 4 accepted; in_req_ready[2] stays 0. One response with tag index 2 → a fifth read is issued on the cycle after the handshake.
- Writes bypass credit: requester 1 at cnt=4 issues writes → every write is granted and cnt[1] remains 4.
- Backpressure: out_req_ready=0 for 3 cycles with requesters 0 and 3 valid → the output holds its payload unchanged, in_req_ready=0, rr_ptr is frozen. After release, issue order resumes from the held pointer.
- Response routing: out_rsp_tag={0xA5, 2'd3}, in_rsp_ready[3]=0 → in_rsp_valid=4'b1000, in_rsp_tag[3]=0xA5, out_rsp_ready=0, cnt[3] unchanged. Setting in_rsp_ready[3]=1 → handshake completes and cnt[3] decrements.
- Reset mid-traffic: drive reset=0 with out_req_valid=1 and cnts nonzero → the next cycle shows out_req_valid=0, cnt=0, rr_ptr=0, and in_req_ready=0 until reset=1.
